brownout_response_ctrl: RTL and testbench

- Sits directly downstream of the supply-rate brownout detector and consumes its per-sample `Brownout` flag, qualified by the same sample strobe.
- Confirms a brownout over consecutive samples, then runs a save-request handshake with the state-save controller.
- Sheds the switched loads, then restores them only after the supply has been reported good for a programmable recovery interval.

---
 rtl/brownout_response_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_brownout_response_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/brownout_response_ctrl.sv
// brownout_response_ctrl
//
// Reacts to the supply-rate brownout detector. A brownout is confirmed
// after CONFIRM_COUNT consecutive qualified hits, then a save is requested
// from the state-save controller. After that the switched loads are shed
// until the supply has been good for RECOVER_CYCLES consecutive cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | normal operation, loads on, waiting for a qualified hit
// CONFIRM  | counting consecutive hits, bounded by a sample window
// SAVE_REQ | save_req asserted, waiting for save_ack or the timeout
// HOLD     | loads shed, waiting for a long enough run of vin_ok
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sample_valid detector sample strobe; qualifies brownout
//   brownout     detector output (per sample)
//   save_ack     state-save completion (level or pulse)
//   vin_ok       supply-good level
//   save_req     request to the state-save controller
//   load_en      switched-load enable, active high
//   alarm        high while an event is in progress
//   save_fail    sticky: a save request timed out
//   event_count  completed events, saturating at 255
//   state        current FSM state (debug)

module brownout_response_ctrl #(
    parameter int unsigned CONFIRM_COUNT  = 3,
    parameter int unsigned WINDOW_CYCLES  = 1000,
    parameter int unsigned SAVE_TIMEOUT   = 5000,
    parameter int unsigned RECOVER_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic       brownout,
    input  logic       save_ack,
    input  logic       vin_ok,
    output logic       save_req,
    output logic       load_en,
    output logic       alarm,
    output logic       save_fail,
    output logic [7:0] event_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONFIRM  = 3'd1,
        SAVE_REQ = 3'd2,
        HOLD     = 3'd3
    } state_t;

    // Timers count up from 0 on entry; the terminal value is one below the
    // programmed interval so the transition lands on the N-th cycle.
    localparam logic [7:0]  CONF_LAST = 8'(CONFIRM_COUNT);
    localparam logic [15:0] WIN_LAST  = 16'(WINDOW_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(SAVE_TIMEOUT - 1);
    localparam logic [15:0] REC_LAST  = 16'(RECOVER_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  conf_cnt;
    logic [15:0] win_cnt;
    logic [15:0] to_cnt;
    logic [15:0] rec_cnt;
    logic        save_req_q;
    logic        load_en_q;
    logic        alarm_q;
    logic        save_fail_q;
    logic [7:0]  event_cnt_q;

    logic hit;
    logic miss;

    assign hit  = sample_valid &  brownout;
    assign miss = sample_valid & ~brownout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            conf_cnt    <= 8'd0;
            win_cnt     <= 16'd0;
            to_cnt      <= 16'd0;
            rec_cnt     <= 16'd0;
            save_req_q  <= 1'b0;
            load_en_q   <= 1'b1;
            alarm_q     <= 1'b0;
            save_fail_q <= 1'b0;
            event_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        conf_cnt <= 8'd1;
                        win_cnt  <= 16'd0;
                        if (CONFIRM_COUNT == 1) begin
                            state_q    <= SAVE_REQ;
                            to_cnt     <= 16'd0;
                            save_req_q <= 1'b1;
                            alarm_q    <= 1'b1;
                            load_en_q  <= 1'b1;
                        end else begin
                            state_q <= CONFIRM;
                        end
                    end
                end

                CONFIRM: begin
                    // A sample on the expiry cycle takes priority over expiry.
                    if (sample_valid) begin
                        win_cnt <= 16'd0;
                        if (hit) begin
                            conf_cnt <= conf_cnt + 8'd1;
                            if (conf_cnt + 8'd1 == CONF_LAST) begin
                                state_q    <= SAVE_REQ;
                                to_cnt     <= 16'd0;
                                save_req_q <= 1'b1;
                                alarm_q    <= 1'b1;
                                load_en_q  <= 1'b1;
                            end
                        end else if (miss) begin
                            state_q  <= IDLE;
                            conf_cnt <= 8'd0;
                        end
                    end else if (win_cnt == WIN_LAST) begin
                        state_q  <= IDLE;
                        conf_cnt <= 8'd0;
                        win_cnt  <= 16'd0;
                    end else begin
                        win_cnt <= win_cnt + 16'd1;
                    end
                end

                SAVE_REQ: begin
                    // Ack on the timeout cycle counts as a successful save.
                    if (save_ack) begin
                        state_q    <= HOLD;
                        rec_cnt    <= 16'd0;
                        save_req_q <= 1'b0;
                        load_en_q  <= 1'b0;
                        alarm_q    <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state_q     <= HOLD;
                        rec_cnt     <= 16'd0;
                        save_req_q  <= 1'b0;
                        load_en_q   <= 1'b0;
                        alarm_q     <= 1'b1;
                        save_fail_q <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end

                HOLD: begin
                    if (vin_ok) begin
                        if (rec_cnt == REC_LAST) begin
                            state_q   <= IDLE;
                            rec_cnt   <= 16'd0;
                            conf_cnt  <= 8'd0;
                            load_en_q <= 1'b1;
                            alarm_q   <= 1'b0;
                            if (event_cnt_q != 8'hFF) begin
                                event_cnt_q <= event_cnt_q + 8'd1;
                            end
                        end else begin
                            rec_cnt <= rec_cnt + 16'd1;
                        end
                    end else begin
                        rec_cnt <= 16'd0;
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    conf_cnt   <= 8'd0;
                    win_cnt    <= 16'd0;
                    to_cnt     <= 16'd0;
                    rec_cnt    <= 16'd0;
                    save_req_q <= 1'b0;
                    load_en_q  <= 1'b1;
                    alarm_q    <= 1'b0;
                end
            endcase
        end
    end

    assign save_req    = save_req_q;
    assign load_en     = load_en_q;
    assign alarm       = alarm_q;
    assign save_fail   = save_fail_q;
    assign event_count = event_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_brownout_response_ctrl.sv
// Self-checking bench for brownout_response_ctrl: a vector table for the
// confirm/interrupt/ack path, then hand sequences for window expiry, save
// timeout, recovery, saturation and asynchronous reset.

module tb_brownout_response_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CONF = 3'd1;
    localparam logic [2:0] S_SAVE = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;

    logic       clk;
    logic       rst_n;
    logic       sample_valid;
    logic       brownout;
    logic       save_ack;
    logic       vin_ok;
    logic       save_req;
    logic       load_en;
    logic       alarm;
    logic       save_fail;
    logic [7:0] event_count;
    logic [2:0] state;

    int checks;
    int failures;

    brownout_response_ctrl #(
        .CONFIRM_COUNT (3),
        .WINDOW_CYCLES (10),
        .SAVE_TIMEOUT  (50),
        .RECOVER_CYCLES(100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .brownout    (brownout),
        .save_ack    (save_ack),
        .vin_ok      (vin_ok),
        .save_req    (save_req),
        .load_en     (load_en),
        .alarm       (alarm),
        .save_fail   (save_fail),
        .event_count (event_count),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sv;
        logic       bo;
        logic       ack;
        logic       vo;
        logic [2:0] st;
        logic       sr;
        logic       le;
        logic       al;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic sv, input logic bo, input logic ack, input logic vo);
        sample_valid = sv;
        brownout     = bo;
        save_ack     = ack;
        vin_ok       = vo;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic sr,
                              input logic le, input logic al);
        check({tag, ".state"},    16'(state),    16'(st));
        check({tag, ".save_req"}, 16'(save_req), 16'(sr));
        check({tag, ".load_en"},  16'(load_en),  16'(le));
        check({tag, ".alarm"},    16'(alarm),    16'(al));
    endtask

    task automatic confirm3();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
    endtask

    task automatic recover100();
        for (int i = 0; i < 100; i++) step(0, 0, 0, 1);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        brownout     = 1'b0;
        save_ack     = 1'b0;
        vin_ok       = 1'b0;

        //            sv bo ack vo  state   sr le al
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, S_IDLE, 1'b0, 1'b1, 1'b0}; // ack ignored in IDLE
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_CONF, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_CONF, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b1, 1'b0}; // miss
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_CONF, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, S_CONF, 1'b0, 1'b1, 1'b0}; // unqualified
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_CONF, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_SAVE, 1'b1, 1'b1, 1'b1}; // 3rd hit
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_SAVE, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_SAVE, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, S_HOLD, 1'b0, 1'b0, 1'b1}; // ack pulse
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, S_HOLD, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, S_HOLD, 1'b0, 1'b0, 1'b1}; // ignored in HOLD

        #12;
        check_outs("reset", S_IDLE, 1'b0, 1'b1, 1'b0);
        check("reset.save_fail", 16'(save_fail), 16'd0);
        check("reset.event_count", 16'(event_count), 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].sv, vecs[i].bo, vecs[i].ack, vecs[i].vo);
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].sr, vecs[i].le, vecs[i].al);
        end

        // Recovery: 60 good, 1 bad, then 100 good.
        for (int i = 0; i < 60; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("rec.after_glitch", 16'(state), 16'(S_HOLD));
        for (int i = 0; i < 99; i++) step(0, 0, 0, 1);
        check_outs("rec.99", S_HOLD, 1'b0, 1'b0, 1'b1);
        check("rec.99.event_count", 16'(event_count), 16'd0);
        step(0, 0, 0, 1);
        check_outs("rec.100", S_IDLE, 1'b0, 1'b1, 1'b0);
        check("rec.100.event_count", 16'(event_count), 16'd1);

        // Window expiry after a single hit.
        step(1, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
        check("win.9", 16'(state), 16'(S_CONF));
        step(0, 0, 0, 0);
        check("win.10", 16'(state), 16'(S_IDLE));

        // Sample landing on the expiry cycle wins.
        step(1, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        check("win.sample_wins", 16'(state), 16'(S_CONF));
        step(1, 0, 0, 0);
        check("win.miss", 16'(state), 16'(S_IDLE));

        // Save timeout.
        confirm3();
        check("to.entry", 16'(state), 16'(S_SAVE));
        for (int i = 0; i < 49; i++) step(0, 0, 0, 0);
        check("to.49.state", 16'(state), 16'(S_SAVE));
        check("to.49.save_fail", 16'(save_fail), 16'd0);
        step(0, 0, 0, 0);
        check_outs("to.50", S_HOLD, 1'b0, 1'b0, 1'b1);
        check("to.50.save_fail", 16'(save_fail), 16'd1);
        recover100();
        check("to.recovered.event_count", 16'(event_count), 16'd2);
        confirm3();
        step(0, 0, 1, 0);
        recover100();
        check("to.sticky.save_fail", 16'(save_fail), 16'd1);
        check("to.sticky.event_count", 16'(event_count), 16'd3);

        // Asynchronous reset in SAVE_REQ.
        confirm3();
        check("rst_save.pre", 16'(state), 16'(S_SAVE));
        #2 rst_n = 1'b0;
        #1;
        check_outs("rst_save", S_IDLE, 1'b0, 1'b1, 1'b0);
        check("rst_save.save_fail", 16'(save_fail), 16'd0);
        check("rst_save.event_count", 16'(event_count), 16'd0);
        #2 rst_n = 1'b1;

        // Asynchronous reset in HOLD.
        confirm3();
        step(0, 0, 1, 0);
        check("rst_hold.pre", 16'(state), 16'(S_HOLD));
        #2 rst_n = 1'b0;
        #1;
        check_outs("rst_hold", S_IDLE, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b1;

        // Ack on the timeout cycle wins.
        confirm3();
        for (int i = 0; i < 49; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("ack50.state", 16'(state), 16'(S_HOLD));
        check("ack50.save_fail", 16'(save_fail), 16'd0);
        recover100();
        check("ack50.event_count", 16'(event_count), 16'd1);

        // Saturation: 255 more events bring the total to 256.
        for (int e = 0; e < 254; e++) begin
            confirm3();
            step(0, 0, 1, 0);
            recover100();
        end
        check("sat.255", 16'(event_count), 16'd255);
        confirm3();
        step(0, 0, 1, 0);
        recover100();
        check("sat.256", 16'(event_count), 16'd255);
        check_outs("sat.end", S_IDLE, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
